// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the position type.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [9:0] pos_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: position, blanking, sync pulses and pixel strobe.
interface vga_sync_gen_if
  import vga_pkg::*;
();

  pos_t xPixel;
  pos_t yPixel;
  logic active_pixels;
  logic hsync;
  logic vsync;
  logic frame_start;
  logic pix_tick;

  modport master (
    output xPixel, yPixel, active_pixels, hsync, vsync, frame_start, pix_tick
  );

  modport slave (
    input xPixel, yPixel, active_pixels, hsync, vsync, frame_start, pix_tick
  );

endinterface

// File: rtl/vga_tick_div.sv
// Pixel strobe generator. VGA_CLKDIV_EN selects clk/2; otherwise every clk.
module vga_tick_div (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  logic r_tick;

`ifdef VGA_CLKDIV_EN
  // Toggle starts at 0, so the first strobe lands on the second clk after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tick <= 1'b0;
    else          r_tick <= ~r_tick;
  end
`else
  // Held at 1 so the very first clk after reset release already updates outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tick <= 1'b1;
    else          r_tick <= 1'b1;
  end
`endif

  assign o_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator; build with VGA_CLKDIV_EN for a clk/2 pixel rate.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
  localparam pos_t H_VIS    = pos_t'(H_ACTIVE);
  localparam pos_t V_VIS    = pos_t'(V_ACTIVE);
  localparam pos_t HS_BEG   = pos_t'(H_ACTIVE + H_FP);
  localparam pos_t HS_END   = pos_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam pos_t VS_BEG   = pos_t'(V_ACTIVE + V_FP);
  localparam pos_t VS_END   = pos_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic w_tick;
  pos_t r_h, r_v;
  pos_t r_x, r_y;
  logic r_act, r_hs, r_vs, r_fs;

  vga_tick_div u_tick (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (w_tick)
  );

  // Outputs present the decode of (h,v) and the position advances on the same tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h   <= '0;
      r_v   <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_act <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_fs  <= 1'b0;
    end else if (w_tick) begin
      r_x   <= r_h;
      r_y   <= r_v;
      r_act <= (r_h < H_VIS) && (r_v < V_VIS);
      r_hs  <= !((r_h >= HS_BEG) && (r_h <= HS_END));
      r_vs  <= !((r_v >= VS_BEG) && (r_v <= VS_END));
      r_fs  <= (r_h == '0) && (r_v == '0);
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign vga.xPixel        = r_x;
  assign vga.yPixel        = r_y;
  assign vga.active_pixels = r_act;
  assign vga.hsync         = r_hs;
  assign vga.vsync         = r_vs;
  assign vga.frame_start   = r_fs;
  assign vga.pix_tick      = w_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing plus a tiny 15x8 raster for frame-level cases.
module tb_vga_sync_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_s_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_gen_if u_if ();
  vga_sync_gen_if u_if_s ();

  vga_sync_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (u_if.master)
  );

  // Small raster: H_TOTAL=15 (hsync h 10..12), V_TOTAL=8 (vsync v 5..6), frame 120 ticks.
  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) u_dut_s (
    .clk   (clk),
    .rst_n (rst_s_n),
    .vga   (u_if_s.master)
  );

  typedef struct {
    int unsigned n;
    int unsigned x;
    int unsigned y;
    bit act, hs, vs, fs;
  } vec_t;

  vec_t tbl [11];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned edge_cnt = 0;

  task automatic tick(input int unsigned k);
    repeat (k) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
  endtask

  task automatic check(input string nm, input int unsigned gx, input int unsigned gy,
                       input bit ga, input bit ghs, input bit gvs, input bit gfs,
                       input int unsigned ex, input int unsigned ey,
                       input bit ea, input bit ehs, input bit evs, input bit efs);
    n_vec++;
    if (gx != ex || gy != ey || ga != ea || ghs != ehs || gvs != evs || gfs != efs) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d act=%0b hs=%0b vs=%0b fs=%0b, want x=%0d y=%0d act=%0b hs=%0b vs=%0b fs=%0b",
               nm, gx, gy, ga, ghs, gvs, gfs, ex, ey, ea, ehs, evs, efs);
    end
  endtask

  task automatic check_d(input string nm, input int unsigned ex, input int unsigned ey,
                         input bit ea, input bit ehs, input bit evs, input bit efs);
    check(nm, int'(u_if.xPixel), int'(u_if.yPixel), u_if.active_pixels, u_if.hsync,
          u_if.vsync, u_if.frame_start, ex, ey, ea, ehs, evs, efs);
  endtask

  task automatic check_s(input string nm, input int unsigned ex, input int unsigned ey,
                         input bit ea, input bit ehs, input bit evs, input bit efs);
    check(nm, int'(u_if_s.xPixel), int'(u_if_s.yPixel), u_if_s.active_pixels, u_if_s.hsync,
          u_if_s.vsync, u_if_s.frame_start, ex, ey, ea, ehs, evs, efs);
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  initial begin
    // n = clk edges after reset release; outputs show linear pixel index n-1.
    tbl[0]  = '{1,    0,   0, 1, 1, 1, 1};
    tbl[1]  = '{2,    1,   0, 1, 1, 1, 0};
    tbl[2]  = '{640,  639, 0, 1, 1, 1, 0};
    tbl[3]  = '{641,  640, 0, 0, 1, 1, 0};
    tbl[4]  = '{656,  655, 0, 0, 1, 1, 0};
    tbl[5]  = '{657,  656, 0, 0, 0, 1, 0};
    tbl[6]  = '{752,  751, 0, 0, 0, 1, 0};
    tbl[7]  = '{753,  752, 0, 0, 1, 1, 0};
    tbl[8]  = '{800,  799, 0, 0, 1, 1, 0};
    tbl[9]  = '{801,  0,   1, 1, 1, 1, 0};
    tbl[10] = '{1601, 0,   2, 1, 1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check_d("reset_state", 0, 0, 0, 1, 1, 0);
    check_s("reset_state_s", 0, 0, 0, 1, 1, 0);

    @(negedge clk);
    rst_n   = 1'b1;
    rst_s_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].n - edge_cnt);
      check_d($sformatf("vec_n%0d", tbl[i].n), tbl[i].x, tbl[i].y,
              tbl[i].act, tbl[i].hs, tbl[i].vs, tbl[i].fs);
    end
    chk_int("pix_tick_const", int'(u_if.pix_tick), 1);

    // Two whole frames of the small raster, starting at an arbitrary phase.
    begin
      int vs_lo = 0, hs_lo = 0, act_cnt = 0, fs_cnt = 0, period = 0, last_fs = 0, bad = 0;
      int prev_y = int'(u_if_s.yPixel);
      for (int i = 0; i < 240; i++) begin
        tick(1);
        if (!u_if_s.vsync) vs_lo++;
        if (!u_if_s.hsync) hs_lo++;
        if (u_if_s.active_pixels) act_cnt++;
        if (u_if_s.frame_start) begin
          fs_cnt++;
          if (last_fs != 0) period = int'(edge_cnt) - last_fs;
          last_fs = int'(edge_cnt);
          if (u_if_s.xPixel != '0 || u_if_s.yPixel != '0) bad++;
        end
        if (prev_y == 7 && u_if_s.yPixel == '0 && !u_if_s.frame_start) bad++;
        prev_y = int'(u_if_s.yPixel);
      end
      chk_int("small_vsync_low_ticks", vs_lo, 60);
      chk_int("small_hsync_low_ticks", hs_lo, 48);
      chk_int("small_active_ticks", act_cnt, 64);
      chk_int("small_frame_starts", fs_cnt, 2);
      chk_int("small_frame_period", period, 120);
      chk_int("small_wrap_fs_errors", bad, 0);
    end

    // Mid-frame reset while both sync pulses are low, at (12,6) of the small raster.
    while (((edge_cnt - 1) % 120) != 102) tick(1);
    check_s("pre_reset_pos", 12, 6, 0, 0, 0, 0);
    rst_s_n = 1'b0;
    #1;
    check_s("async_reset", 0, 0, 0, 1, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s_n = 1'b1;
    @(posedge clk);
    #1;
    check_s("restart_first", 0, 0, 1, 1, 1, 1);
    @(posedge clk);
    #1;
    check_s("restart_second", 1, 0, 1, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port xPixel, output, 10 bits: horizontal position, 0..H_TOTAL-1.
REQ-008 SHALL have port yPixel, output, 10 bits: vertical position, 0..V_TOTAL-1.
REQ-009 SHALL have port active_pixels, output, 1 bit: high when xPixel<H_ACTIVE and yPixel<V_ACTIVE.
REQ-010 SHALL have ports hsync and vsync, outputs, 1 bit each: active-low sync pulses.
REQ-011 SHALL have port frame_start, output, 1 bit: one-tick pulse at position (0,0).
REQ-012 SHALL have port pix_tick, output, 1 bit: high on clk cycles where outputs update.

Function
REQ-013 SHALL derive H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-014 SHALL hold an internal position (h,v); on every pix_tick, all outputs SHALL register values decoded from (h,v), then (h,v) SHALL advance.
REQ-015 SHALL advance h by 1 per tick; at h=H_TOTAL-1, h wraps to 0 and v advances by 1.
REQ-016 SHALL wrap v to 0 when h wraps at v=V_TOTAL-1.
REQ-017 SHALL drive hsync low exactly for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
REQ-018 SHALL drive vsync low exactly for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for the whole line.
REQ-019 SHALL assert frame_start for exactly one tick per frame, when presenting (0,0).
REQ-020 SHALL hold all outputs stable between ticks.
REQ-021 SHALL use 10-bit counters; parameters giving H_TOTAL or V_TOTAL above 1024 are unsupported.

Reset
REQ-022 SHALL, while rst_n=0, force h=0, v=0, xPixel=0, yPixel=0, active_pixels=0, hsync=1, vsync=1, frame_start=0.
REQ-023 SHALL, on the first pix_tick after rst_n deassertion, present (0,0) with active_pixels=1 and frame_start=1.
REQ-024 SHALL, on reset asserted mid-frame, abort immediately; no partial sync pulse SHALL persist.

Configuration
REQ-025 With VGA_CLKDIV_EN defined, SHALL assert pix_tick on alternate clk cycles (clk/2, for 50 MHz -> 25 MHz); the toggle resets to 0, so the first tick is the second clk after reset release.
REQ-026 Without VGA_CLKDIV_EN, pix_tick SHALL be constant 1 after reset; outputs update every clk.

Structure
REQ-027 SHALL place default timing constants (640/16/96/48, 480/10/2/33) and the derived totals in shared package vga_pkg.
REQ-028 SHALL isolate the tick generation in sub-module vga_tick_div.

Verification
REQ-029 Reset release, no divider: first clk -> xPixel=0, yPixel=0, active_pixels=1, frame_start=1; next clk -> xPixel=1, frame_start=0.
REQ-030 Line scan: hsync falls when xPixel=656, rises when xPixel=752; active_pixels falls at xPixel=640; line period 800 ticks.
REQ-031 Frame scan: vsync low for yPixel 490..491 (1600 ticks); yPixel wraps 524->0 with frame_start; frame period 420000 ticks.
REQ-032 With VGA_CLKDIV_EN: pix_tick alternates; xPixel increments every 2 clk; frame period 840000 clk.
REQ-033 rst_n pulsed low at (700,491): outputs immediately 0/0, active 0, hsync=1, vsync=1; restart at (0,0) per REQ-023.
